sync_fifo_flags: RTL and testbench

- Single-clock successor to the dual-clock FIFO: same push/pop contract (winc/rinc, wfull/rempty), generalised with occupancy count, programmable almost-full/almost-empty thresholds, selectable read mode (first-word-fall-through or registered), and overflow/underflow error pulses.
- Used for buffering between same-clock pipeline stages where CDC synchronisers are unnecessary.
- Depth is 2**ASIZE.

---
 rtl/sync_fifo_flags_if.sv | 27 ++
 rtl/sync_fifo_flags.sv | 83 ++++++++
 tb/tb_sync_fifo_flags.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_flags_if.sv
// Push/pop bundle for sync_fifo_flags: write side, read side, occupancy and error pulses.
interface sync_fifo_flags_if #(
  parameter int unsigned WSIZE = 8,
  parameter int unsigned ASIZE = 4
);
  logic             winc;
  logic [WSIZE-1:0] wdata;
  logic             wfull;
  logic             walmost_full;
  logic             rinc;
  logic [WSIZE-1:0] rdata;
  logic             rempty;
  logic             ralmost_empty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output winc, wdata, rinc,
    input  wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc,
    output wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// selectable FWFT or registered read data, and overflow/underflow pulses.
module sync_fifo_flags #(
  parameter int unsigned WSIZE      = 8,
  parameter int unsigned ASIZE      = 4,
  parameter int unsigned AFULL_LVL  = 12,
  parameter int unsigned AEMPTY_LVL = 4,
  parameter int unsigned FWFT       = 1
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_flags_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ASIZE;
  localparam logic [ASIZE:0] DepthC  = (ASIZE + 1)'(DEPTH);
  localparam logic [ASIZE:0] AfullC  = (ASIZE + 1)'(AFULL_LVL);
  localparam logic [ASIZE:0] AemptyC = (ASIZE + 1)'(AEMPTY_LVL);

  logic [ASIZE:0]   wptr_q, rptr_q, count_q, count_d;
  logic [ASIZE-1:0] waddr, raddr;
  logic             overflow_q, underflow_q;
  logic             wen, ren;
  logic [WSIZE-1:0] mem [DEPTH];

  assign waddr = wptr_q[ASIZE-1:0];
  assign raddr = rptr_q[ASIZE-1:0];

  // Accept decisions use only registered flags, so full blocks writes even with a read.
  assign wen = bus.winc && !bus.wfull;
  assign ren = bus.rinc && !bus.rempty;

  assign bus.wfull         = (count_q == DepthC);
  assign bus.rempty        = (count_q == '0);
  assign bus.walmost_full  = (count_q >= AfullC);
  assign bus.ralmost_empty = (count_q <= AemptyC);
  assign bus.count         = count_q;
  assign bus.overflow      = overflow_q;
  assign bus.underflow     = underflow_q;

  // Occupancy next-state: simultaneous push and pop cancel.
  always_comb begin
    count_d = count_q;
    unique case ({wen, ren})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers, count and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wen) wptr_q <= wptr_q + 1'b1;
      if (ren) rptr_q <= rptr_q + 1'b1;
      count_q     <= count_d;
      overflow_q  <= bus.winc && bus.wfull;
      underflow_q <= bus.rinc && bus.rempty;
    end
  end

  // Storage array; contents survive reset but are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= bus.wdata;
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.rdata = mem[raddr];
  end else begin : g_reg
    logic [WSIZE-1:0] rdata_q;
    // Registered read data, loaded only on an accepted pop.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)      rdata_q <= '0;
      else if (ren) rdata_q <= mem[raddr];
    end
    assign bus.rdata = rdata_q;
  end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench: FWFT and registered-read instances driven identically,
// compared against a queue-based reference model.
module tb_sync_fifo_flags;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] q[$];
  logic [7:0] rd0_exp = 8'h00;

  always #5 clk = ~clk;

  sync_fifo_flags_if #(.WSIZE(8), .ASIZE(4)) bus1 ();
  sync_fifo_flags_if #(.WSIZE(8), .ASIZE(4)) bus0 ();

  sync_fifo_flags #(.WSIZE(8), .ASIZE(4), .AFULL_LVL(12), .AEMPTY_LVL(4), .FWFT(1)) u_fwft (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  sync_fifo_flags #(.WSIZE(8), .ASIZE(4), .AFULL_LVL(12), .AEMPTY_LVL(4), .FWFT(0)) u_reg (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  logic ov_exp = 1'b0;
  logic un_exp = 1'b0;

  // Watchdog against a stuck run.
  initial begin
    #2000000;
    $display("FAIL timeout observed no finish required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count1", 32'(bus1.count), n);
    chk("count0", 32'(bus0.count), n);
    chk("wfull", 32'(bus1.wfull), 32'(n == DEPTH));
    chk("rempty", 32'(bus1.rempty), 32'(n == 0));
    chk("walmost_full", 32'(bus1.walmost_full), 32'(n >= 12));
    chk("ralmost_empty", 32'(bus1.ralmost_empty), 32'(n <= 4));
    chk("wfull0", 32'(bus0.wfull), 32'(n == DEPTH));
    chk("rempty0", 32'(bus0.rempty), 32'(n == 0));
    chk("overflow", 32'(bus1.overflow), 32'(ov_exp));
    chk("underflow", 32'(bus1.underflow), 32'(un_exp));
    chk("overflow0", 32'(bus0.overflow), 32'(ov_exp));
    chk("underflow0", 32'(bus0.underflow), 32'(un_exp));
    if (n > 0) chk("rdata_fwft", 32'(bus1.rdata), 32'(q[0]));
    chk("rdata_reg", 32'(bus0.rdata), 32'(rd0_exp));
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r);
    bus1.winc = w; bus1.wdata = d; bus1.rinc = r;
    bus0.winc = w; bus0.wdata = d; bus0.rinc = r;
  endtask

  // One clock of stimulus, then update the model and compare.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    bit wen_m, ren_m;
    logic [7:0] tmp;
    drive(w, d, r);
    wen_m  = w && (q.size() != DEPTH);
    ren_m  = r && (q.size() != 0);
    ov_exp = w && (q.size() == DEPTH);
    un_exp = r && (q.size() == 0);
    @(posedge clk);
    #1;
    if (ren_m) begin
      tmp = q.pop_front();
      rd0_exp = tmp;
    end
    if (wen_m) q.push_back(d);
    check_all();
  endtask

  initial begin
    logic [7:0] dv;
    drive(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Fill to full with 0x00..0x0F.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    // Write while full: rejected, overflow pulse.
    step(1'b1, 8'hAA, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    // Drain; model queue holds 0x00..0x0F so 0xAA would show as a mismatch.
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", 32'(bus1.rdata), i);
      step(1'b0, 8'h00, 1'b1);
      chk("drain_reg", 32'(bus0.rdata), i);
    end
    // Read while empty: underflow pulse, registered rdata holds 0x0F.
    step(1'b0, 8'h00, 1'b1);
    chk("hold_0f", 32'(bus0.rdata), 32'h0F);
    step(1'b0, 8'h00, 1'b0);

    // Steady state at count 5 across several pointer wraps.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h45 + i), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);

    // Single word into an empty FIFO, then pop.
    step(1'b1, 8'h5C, 1'b0);
    chk("fwft_5c", 32'(bus1.rdata), 32'h5C);
    step(1'b0, 8'h00, 1'b1);
    chk("reg_5c", 32'(bus0.rdata), 32'h5C);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      dv = 8'($urandom);
      step(1'($urandom_range(0, 1)), dv, 1'($urandom_range(0, 1)));
    end

    // Drain, fill to 9, then assert reset between clock edges.
    while (q.size() > 0) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h90 + i), 1'b0);
    drive(1'b1, 8'hEE, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    q.delete();
    rd0_exp = 8'h00;
    ov_exp = 1'b0;
    un_exp = 1'b0;
    chk("rst_count", 32'(bus1.count), 0);
    chk("rst_rempty", 32'(bus1.rempty), 1);
    chk("rst_wfull", 32'(bus1.wfull), 0);
    check_all();
    drive(1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
    step(1'b1, 8'h33, 1'b0);
    chk("post_rst_fwft", 32'(bus1.rdata), 32'h33);
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_reg", 32'(bus0.rdata), 32'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
